// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared types and constants for the UART boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    localparam int c_byte_w       = 8;
    localparam int c_word_w       = 32;
    localparam int c_size_bytes   = 4;

    localparam logic [7:0] c_sync_byte_def = 8'h99;
    localparam logic [7:0] c_done_byte_def = 8'hAA;

    typedef enum logic [2:0] {
        SEND_SYNC = 3'd0,
        RECV_SIZE = 3'd1,
        RECV_PROG = 3'd2,
        SEND_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/loader_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : loader_tx_arbiter
// Description : Issues one-cycle UART_TX start pulses for the loader. A
//               request is accepted only when the UART is idle and no pulse
//               was issued in the previous cycle (UART busy lags one cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module loader_tx_arbiter
    import program_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [c_byte_w-1:0] i_data,
    input  logic                i_tx_busy,
    output logic                o_accept,
    output logic                o_tx_start,
    output logic [c_byte_w-1:0] o_tx_sdata
);

    logic                r_busy_wait;
    logic                r_tx_start;
    logic [c_byte_w-1:0] r_tx_sdata;
    logic                w_accept;

    assign w_accept   = i_req & ~i_tx_busy & ~r_busy_wait;
    assign o_accept   = w_accept;
    assign o_tx_start = r_tx_start;
    assign o_tx_sdata = r_tx_sdata;

    // Register the start pulse and data; busy_wait masks the cycle after a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_wait <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_sdata  <= '0;
        end else begin
            r_busy_wait <= w_accept;
            r_tx_start  <= w_accept;
            if (w_accept) begin
                r_tx_sdata <= i_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : UART boot loader. Sends SYNC_BYTE, receives a 32-bit LE size,
//               writes that many bytes into instruction memory as LE words,
//               sends DONE_BYTE and raises load_done.
//               Optional macro PROGRAM_LOADER_CHECKSUM_EN adds an XOR checksum
//               port and transmits it right after DONE_BYTE.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                   IMEM_ADDR_WIDTH = 15,
    parameter logic [c_byte_w-1:0]  SYNC_BYTE       = c_sync_byte_def,
    parameter logic [c_byte_w-1:0]  DONE_BYTE       = c_done_byte_def
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [c_byte_w-1:0]        rx_rdata,
    input  logic                       rx_rdata_ready,
    input  logic                       tx_busy,
    output logic [c_byte_w-1:0]        tx_sdata,
    output logic                       tx_start,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [c_word_w-1:0]        imem_wdata,
    output logic                       load_done,
    output logic                       overflow
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic [c_byte_w-1:0]        checksum
`endif
);

    localparam logic [IMEM_ADDR_WIDTH:0] c_widx_one = {{IMEM_ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                    r_state;
    state_t                    w_state_next;
    logic [c_word_w-1:0]       r_size;
    logic [c_word_w-1:0]       r_byte_cnt;
    logic [c_word_w-1:0]       r_word;
    logic [1:0]                r_size_cnt;
    // One extra bit so "memory full" is visible without the address wrapping.
    logic [IMEM_ADDR_WIDTH:0]  r_widx;
    logic                      r_we;
    logic [c_word_w-1:0]       r_wdata;
    logic                      r_overflow;

    logic                      w_tx_req;
    logic [c_byte_w-1:0]       w_tx_data;
    logic                      w_tx_accept;
    logic [c_word_w-1:0]       w_size_shift;
    logic [1:0]                w_lane;
    logic [c_word_w-1:0]       w_word_fill;
    logic                      w_last_byte;
    logic                      w_prog_strobe;
    logic                      w_word_done;
    logic [IMEM_ADDR_WIDTH:0]  w_widx_eff;
    logic                      w_fits;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [c_byte_w-1:0]       r_cksum;
    logic                      r_done_sent;
`endif

    assign w_size_shift  = {rx_rdata, r_size[c_word_w-1:c_byte_w]};
    assign w_lane        = r_byte_cnt[1:0];
    assign w_last_byte   = ((r_byte_cnt + 32'd1) == r_size);
    assign w_prog_strobe = (r_state == RECV_PROG) & rx_rdata_ready;
    assign w_word_done   = w_prog_strobe & ((w_lane == 2'd3) | w_last_byte);
    // A write issued last cycle has not yet advanced r_widx; account for it.
    assign w_widx_eff    = r_widx + (r_we ? c_widx_one : '0);
    assign w_fits        = ~w_widx_eff[IMEM_ADDR_WIDTH];

    // Merge the incoming byte into its lane of the word being assembled.
    always_comb begin
        w_word_fill = r_word;
        w_word_fill[{w_lane, 3'b000} +: c_byte_w] = rx_rdata;
    end

    loader_tx_arbiter u_tx_arbiter (
        .clk        (clk),
        .reset      (reset),
        .i_req      (w_tx_req),
        .i_data     (w_tx_data),
        .i_tx_busy  (tx_busy),
        .o_accept   (w_tx_accept),
        .o_tx_start (tx_start),
        .o_tx_sdata (tx_sdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEND_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and transmit-request decode.
    always_comb begin
        w_state_next = r_state;
        w_tx_req     = 1'b0;
        w_tx_data    = SYNC_BYTE;
        case (r_state)
            SEND_SYNC: begin
                w_tx_req = 1'b1;
                if (w_tx_accept) begin
                    w_state_next = RECV_SIZE;
                end
            end
            RECV_SIZE: begin
                if (rx_rdata_ready && (r_size_cnt == 2'd3)) begin
                    w_state_next = (w_size_shift == '0) ? SEND_DONE : RECV_PROG;
                end
            end
            RECV_PROG: begin
                if (w_prog_strobe && w_last_byte) begin
                    w_state_next = SEND_DONE;
                end
            end
            SEND_DONE: begin
                w_tx_req  = 1'b1;
                w_tx_data = DONE_BYTE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (r_done_sent) begin
                    w_tx_data = r_cksum;
                end
                if (w_tx_accept && r_done_sent) begin
                    w_state_next = DONE;
                end
`else
                if (w_tx_accept) begin
                    w_state_next = DONE;
                end
`endif
            end
            DONE: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = SEND_SYNC;
            end
        endcase
    end

    // Size capture, byte counting, word assembly and memory write issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size     <= '0;
            r_size_cnt <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_widx     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_widx <= r_widx + c_widx_one;
            end
            if ((r_state == RECV_SIZE) && rx_rdata_ready) begin
                r_size     <= w_size_shift;
                r_size_cnt <= r_size_cnt + 2'd1;
            end
            if (w_prog_strobe) begin
                r_byte_cnt <= r_byte_cnt + 32'd1;
                r_word     <= w_word_done ? '0 : w_word_fill;
            end
            if (w_word_done) begin
                if (w_fits) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word_fill;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR of program bytes and tracking of the DONE_BYTE send.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cksum     <= '0;
            r_done_sent <= 1'b0;
        end else begin
            if (w_prog_strobe) begin
                r_cksum <= r_cksum ^ rx_rdata;
            end
            if ((r_state == SEND_DONE) && w_tx_accept) begin
                r_done_sent <= 1'b1;
            end
        end
    end

    assign checksum = r_cksum;
`endif

    assign imem_we    = r_we;
    assign imem_addr  = r_widx[IMEM_ADDR_WIDTH-1:0];
    assign imem_wdata = r_wdata;
    assign load_done  = (r_state == DONE);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire
